// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one ALU datapath between NUM_REQ requesters using round-robin
//   arbitration. An accepted operation is registered into the issue stage,
//   which drives the ALU for one cycle. The ALU result is registered into
//   the response stage. Accept-to-response latency is a fixed 2 cycles, and
//   one operation can be accepted every cycle.
//
//   Optional feature macro: ALU_ARB_PERF_EN
//     Adds one saturating 16-bit accept counter per requester (GrantCount)
//     and a synchronous clear input (ClrCount).
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   ReqValid     per-requester operation valid
//   ReqReady     per-requester grant (one-hot or zero, combinational)
//   ReqOp/A/B    flattened per-requester ALUControl code and operands
//   Hold         blocks new grants; in-flight operations still complete
//   ALUControl, SrcA, SrcB   registered drive to the ALU
//   ALUResult, Zero          combinational return from the ALU
//   RspValid     one-hot, one-cycle response pulse to the original requester
//   RspResult, RspZero       shared response data, qualified by RspValid
//   Busy         issue or response stage holds a valid operation
//   GrantCount, ClrCount     (ALU_ARB_PERF_EN only) accept counters and clear
module alu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         ReqValid,
  output logic [NUM_REQ-1:0]         ReqReady,
  input  logic [3*NUM_REQ-1:0]       ReqOp,
  input  logic [D_WIDTH*NUM_REQ-1:0] ReqA,
  input  logic [D_WIDTH*NUM_REQ-1:0] ReqB,
  input  logic                       Hold,
  output logic [2:0]                 ALUControl,
  output logic [D_WIDTH-1:0]         SrcA,
  output logic [D_WIDTH-1:0]         SrcB,
  input  logic [D_WIDTH-1:0]         ALUResult,
  input  logic                       Zero,
  output logic [NUM_REQ-1:0]         RspValid,
  output logic [D_WIDTH-1:0]         RspResult,
  output logic                       RspZero,
`ifdef ALU_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]      GrantCount,
  input  logic                       ClrCount,
`endif
  output logic                       Busy
);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               iss_valid_q, iss_valid_d;
  logic [PTR_W-1:0]   iss_id_q, iss_id_d;
  logic [2:0]         alu_ctrl_q, alu_ctrl_d;
  logic [D_WIDTH-1:0] src_a_q, src_a_d;
  logic [D_WIDTH-1:0] src_b_q, src_b_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [D_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  int unsigned        scan_idx;

  // Circular scan starting at ptr_q; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    ReqReady    = '0;
    if (!Hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        scan_idx = (32'(ptr_q) + i) % NUM_REQ;
        if (!grant_found && ReqValid[scan_idx]) begin
          grant_found = 1'b1;
          grant_idx   = PTR_W'(scan_idx);
        end
      end
    end
    if (grant_found) ReqReady[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d        = ptr_q;
    iss_valid_d  = 1'b0;
    iss_id_d     = '0;
    alu_ctrl_d   = '0;
    src_a_d      = '0;
    src_b_d      = '0;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    if (grant_found) begin
      ptr_d       = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      iss_valid_d = 1'b1;
      iss_id_d    = grant_idx;
      alu_ctrl_d  = ReqOp[3*grant_idx +: 3];
      src_a_d     = ReqA[D_WIDTH*grant_idx +: D_WIDTH];
      src_b_d     = ReqB[D_WIDTH*grant_idx +: D_WIDTH];
    end

    // Result capture only when the issue stage carried a real operation, so
    // the idle 0+0 ADD never overwrites the last response data.
    if (iss_valid_q) begin
      rsp_valid_d[iss_id_q] = 1'b1;
      rsp_result_d          = ALUResult;
      rsp_zero_d            = Zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      iss_valid_q  <= 1'b0;
      iss_id_q     <= '0;
      alu_ctrl_q   <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      iss_valid_q  <= iss_valid_d;
      iss_id_q     <= iss_id_d;
      alu_ctrl_q   <= alu_ctrl_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign ALUControl = alu_ctrl_q;
  assign SrcA       = src_a_q;
  assign SrcB       = src_b_q;
  assign RspValid   = rsp_valid_q;
  assign RspResult  = rsp_result_q;
  assign RspZero    = rsp_zero_q;
  assign Busy       = iss_valid_q | (|rsp_valid_q);

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ClrCount) begin
        gcnt_d[16*i +: 16] = '0;
      end else if (grant_found && (grant_idx == PTR_W'(i)) &&
                   (gcnt_q[16*i +: 16] != '1)) begin
        gcnt_d[16*i +: 16] = gcnt_q[16*i +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign GrantCount = gcnt_q;
`endif

endmodule
